// File: rtl/dpa_train_tx.sv
// dpa_train_tx
// ----------------------------------------------------------------------------
// Transmit-side companion to the DPA alignment FSM. On request it sends a
// fixed, transition-rich training word long enough for the receiver to sweep
// its delay taps. It then waits for the receiver's Locked/Error sideband and,
// once locked, passes payload words through a valid/ready handshake to the
// serializer.
//
// Ports
//   clk          in   sole clock
//   rst          in   synchronous active-high reset
//   train_req    in   level-sampled request to start / restart training
//   rx_locked    in   receiver Locked, synchronous to clk
//   rx_error     in   receiver Error, synchronous to clk
//   data_in      in   payload word
//   data_valid   in   data_in valid
//   data_ready   out  payload accepted this cycle (high exactly in DATA)
//   tx_data      out  registered word to the OSERDES (1-cycle latency)
//   training     out  high in TRAIN and WAIT_LOCK
//   timeout_err  out  sticky lock-timeout flag
//   retry_cnt    out  saturating count of rx_error-triggered retrains
//   state        out  one-hot debug state: IDLE=1 TRAIN=2 WAIT_LOCK=4 DATA=8
//
// Optional build macro
//   DPA_TX_PRBS_IDLE_EN  when defined, DATA cycles without a payload word carry
//                        PRBS-7 (x^7+x^6+1) fill instead of IDLE_WORD. The
//                        fill generator produces 8-bit words, so this option
//                        assumes DATA_WIDTH == 8.
// ----------------------------------------------------------------------------
module dpa_train_tx #(
    parameter int                    DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN   = 8'h0F,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD       = 8'h00,
    parameter int                    MIN_TRAIN_WORDS = 64,
    parameter int                    LOCK_TIMEOUT    = 1024,
    parameter int                    COUNTER_WIDTH   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  train_req,
    input  logic                  rx_locked,
    input  logic                  rx_error,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  training,
    output logic                  timeout_err,
    output logic [3:0]            retry_cnt,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_TRAIN = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DATA  = 4'b1000
    } state_t;

    // One counter serves both the training length and the lock timeout; it
    // is cleared on every entry to TRAIN and to WAIT_LOCK.
    localparam logic [COUNTER_WIDTH-1:0] TRAIN_LAST   = COUNTER_WIDTH'(MIN_TRAIN_WORDS - 1);
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(LOCK_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     timeout_d;
    logic [3:0]               retry_d;
    logic [DATA_WIDTH-1:0]    tx_d;
    logic [DATA_WIDTH-1:0]    fill_word;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef DPA_TX_PRBS_IDLE_EN
    localparam logic [6:0] PRBS_SEED = 7'h7F;

    logic [6:0]  lfsr_q, lfsr_d;
    logic [14:0] prbs_step;

    // Runs the x^7+x^6+1 generator for 8 bits. The bit shifted out of the
    // MSB is the output bit, first bit to word[7]. Returns {next_lfsr, word};
    // from the all-ones seed the first word is 8'hFE.
    function automatic logic [14:0] prbs7_fill(input logic [6:0] seed);
        logic [6:0] s;
        logic [7:0] w;
        s = seed;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            w[i] = s[6];
            s    = {s[5:0], s[6] ^ s[5]};
        end
        return {s, w};
    endfunction

    assign prbs_step = prbs7_fill(lfsr_q);
    assign fill_word = prbs_step[7:0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_d == ST_DATA && state_q != ST_DATA) begin
            lfsr_d = PRBS_SEED;
        end else if (state_q == ST_DATA && !data_valid) begin
            lfsr_d = prbs_step[14:8];
        end
    end

    // The generator is always reseeded before it is first used, so it needs
    // no reset.
    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end
`else
    assign fill_word = IDLE_WORD;
`endif

    // Next-state and sideband updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_err;
        retry_d   = retry_cnt;
        case (state_q)
            ST_IDLE: begin
                if (train_req) begin
                    state_d   = ST_TRAIN;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    retry_d   = 4'd0;
                end
            end
            ST_TRAIN: begin
                cnt_d = cnt_q + COUNTER_WIDTH'(1);
                if (cnt_q == TRAIN_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + COUNTER_WIDTH'(1);
                if (rx_error) begin
                    state_d = ST_TRAIN;
                    cnt_d   = '0;
                    retry_d = sat_inc4(retry_cnt);
                end else if (rx_locked) begin
                    state_d = ST_DATA;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (!rx_locked || train_req) begin
                    state_d = ST_TRAIN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output word is chosen from the pre-edge state, giving one cycle of
    // latency; the last payload word accepted in DATA still goes out.
    always_comb begin
        tx_d = IDLE_WORD;
        case (state_q)
            ST_DATA:           tx_d = data_valid ? data_in : fill_word;
            ST_TRAIN, ST_WAIT: tx_d = TRAIN_PATTERN;
            default:           tx_d = IDLE_WORD;
        endcase
    end

    // ---- register stage: state, sideband and serializer word ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
            retry_cnt   <= 4'd0;
            training    <= 1'b0;
            tx_data     <= IDLE_WORD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_err <= timeout_d;
            retry_cnt   <= retry_d;
            training    <= (state_d == ST_TRAIN) || (state_d == ST_WAIT);
            tx_data     <= tx_d;
        end
    end

    assign data_ready = (state_q == ST_DATA);
    assign state      = state_q;

endmodule

// File: tb/tb_dpa_train_tx.sv
// Bench for dpa_train_tx: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_dpa_train_tx;

    logic       clk;
    logic       rst;
    logic       train_req;
    logic       rx_locked;
    logic       rx_error;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] tx_data;
    logic       training;
    logic       timeout_err;
    logic [3:0] retry_cnt;
    logic [3:0] dut_state;

    int vectors     = 0;
    int miscompares = 0;

    dpa_train_tx dut (
        .clk        (clk),
        .rst        (rst),
        .train_req  (train_req),
        .rx_locked  (rx_locked),
        .rx_error   (rx_error),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_data    (tx_data),
        .training   (training),
        .timeout_err(timeout_err),
        .retry_cnt  (retry_cnt),
        .state      (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- behavioural model ----------------
    // PRBS-7 reference as a bit sequence: b[n] = b[n-7] ^ b[n-6], starting
    // from seven ones; fill words are consecutive 8-bit chunks, MSB first.
    bit prbs_bits[127];
    initial begin
        for (int n = 0; n < 7; n++) prbs_bits[n] = 1'b1;
        for (int n = 7; n < 127; n++) prbs_bits[n] = prbs_bits[n-7] ^ prbs_bits[n-6];
    end

    function automatic logic [7:0] ref_fill(input int p);
        logic [7:0] w;
        w = 8'h00;
`ifdef DPA_TX_PRBS_IDLE_EN
        for (int k = 0; k < 8; k++) w[7-k] = prbs_bits[(p + k) % 127];
`endif
        return w;
    endfunction

    // Phase codes are the visible debug encoding: 1 idle, 2 train, 4 wait, 8 data.
    int         m_phase = 1;
    int         m_age   = 0;    // cycles spent so far in the current phase
    int         m_retry = 0;
    bit         m_to    = 0;
    bit         m_trn   = 0;
    logic [7:0] m_tx    = 8'h00;
    int         m_pidx  = 0;    // position in the PRBS bit sequence
    bit         model_on = 0;
    int         m_next;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 1;
            m_age    = 0;
            m_retry  = 0;
            m_to     = 0;
            m_trn    = 0;
            m_tx     = 8'h00;
            m_pidx   = 0;
            model_on = 1;
        end else begin
            if (m_phase == 8) begin
                if (data_valid) m_tx = data_in;
                else begin
                    m_tx   = ref_fill(m_pidx);
                    m_pidx = (m_pidx + 8) % 127;
                end
            end else if (m_phase == 2 || m_phase == 4) m_tx = 8'h0F;
            else m_tx = 8'h00;

            m_next = m_phase;
            if (m_phase == 1) begin
                if (train_req) begin
                    m_next = 2; m_age = 0; m_to = 0; m_retry = 0;
                end
            end else if (m_phase == 2) begin
                m_age++;
                if (m_age == 64) begin m_next = 4; m_age = 0; end
            end else if (m_phase == 4) begin
                m_age++;
                if (rx_error) begin
                    m_next = 2; m_age = 0;
                    if (m_retry < 15) m_retry++;
                end else if (rx_locked) m_next = 8;
                else if (m_age == 1024) begin m_next = 1; m_to = 1; m_age = 0; end
            end else begin
                if (!rx_locked || train_req) begin m_next = 2; m_age = 0; end
            end
            if (m_next == 8 && m_phase != 8) m_pidx = 0;
            m_phase = m_next;
            m_trn   = (m_next == 2 || m_next == 4);
        end
    end

    // Single compare process, every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (model_on) begin
            check("state",       dut_state,   m_phase);
            check("tx_data",     tx_data,     m_tx);
            check("data_ready",  data_ready,  m_phase == 8);
            check("training",    training,    m_trn);
            check("timeout_err", timeout_err, m_to);
            check("retry_cnt",   retry_cnt,   m_retry);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] exp_fill0, exp_fill1;

    initial begin
`ifdef DPA_TX_PRBS_IDLE_EN
        exp_fill0 = 8'hFE;
        exp_fill1 = 8'h04;
`else
        exp_fill0 = 8'h00;
        exp_fill1 = 8'h00;
`endif
        rst = 1; train_req = 0; rx_locked = 0; rx_error = 0;
        data_in = 8'h00; data_valid = 0;

        // Reset and idle
        step(5);
        rst = 0;
        check("rst_state", dut_state, 4'd1);
        check("rst_tx", tx_data, 8'h00);
        check("rst_ready", data_ready, 1'b0);
        check("rst_training", training, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_retry", retry_cnt, 4'd0);
        step(3);
        check("idle_hold", dut_state, 4'd1);

        // Nominal lock: request at edge N
        train_req = 1;
        step(1);
        train_req = 0;
        check("nom_state_train", dut_state, 4'd2);
        check("nom_tx_idle_still", tx_data, 8'h00);
        step(1);
        check("nom_tx_pattern", tx_data, 8'h0F);
        check("nom_training", training, 1'b1);
        step(62);
        check("nom_train_len", dut_state, 4'd2);
        step(1);
        check("nom_wait", dut_state, 4'd4);
        step(5);
        rx_locked = 1;
        step(1);
        check("nom_data", dut_state, 4'd8);
        check("nom_ready", data_ready, 1'b1);
        check("nom_training_off", training, 1'b0);
        data_valid = 1; data_in = 8'hA5;
        step(1);
        check("nom_payload", tx_data, 8'hA5);
        data_valid = 0;
        step(1);
        check("nom_fill0", tx_data, exp_fill0);
        step(1);
        check("nom_fill1", tx_data, exp_fill1);

        // Lock loss in DATA at edge M
        data_valid = 1; data_in = 8'h3C; rx_locked = 0;
        step(1);
        data_valid = 0;
        check("loss_last_word", tx_data, 8'h3C);
        check("loss_ready", data_ready, 1'b0);
        check("loss_state", dut_state, 4'd2);
        step(1);
        check("loss_pattern", tx_data, 8'h0F);

        // Timeout: TRAIN entered at M, IDLE expected at M+64+1024
        step(1086);
        check("to_still_wait", dut_state, 4'd4);
        step(1);
        check("to_idle", dut_state, 4'd1);
        check("to_flag", timeout_err, 1'b1);
        step(2);
        check("to_sticky", timeout_err, 1'b1);
        train_req = 1;
        step(1);
        train_req = 0;
        check("to_cleared", timeout_err, 1'b0);
        check("to_retrain", dut_state, 4'd2);

        // Error retry, three times
        step(64);
        check("err_wait0", dut_state, 4'd4);
        for (int r = 0; r < 3; r++) begin
            rx_error = 1;
            step(1);
            rx_error = 0;
            check("err_back_train", dut_state, 4'd2);
            check("err_training", training, 1'b1);
            step(64);
            check("err_wait", dut_state, 4'd4);
        end
        rx_locked = 1;
        step(1);
        check("err_data", dut_state, 4'd8);
        check("err_retry3", retry_cnt, 4'd3);

        // train_req in DATA retrains without touching retry_cnt
        train_req = 1;
        step(1);
        train_req = 0; rx_locked = 0;
        check("req_retrain", dut_state, 4'd2);
        check("req_retry_kept", retry_cnt, 4'd3);

        // Retry saturation: thirteen more errors
        for (int r = 0; r < 13; r++) begin
            step(64);
            rx_error = 1;
            step(1);
            rx_error = 0;
        end
        check("sat_retry", retry_cnt, 4'd15);
        step(64);
        rx_locked = 1;
        step(1);
        check("sat_data", dut_state, 4'd8);
        step(1);
        check("fill_entry0", tx_data, exp_fill0);
        step(1);
        check("fill_entry1", tx_data, exp_fill1);

        // Reset mid-operation drops the word in flight
        data_valid = 1; data_in = 8'h5A; rst = 1;
        step(1);
        rst = 0; data_valid = 0; rx_locked = 0;
        check("midrst_state", dut_state, 4'd1);
        check("midrst_tx", tx_data, 8'h00);
        check("midrst_retry", retry_cnt, 4'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            rst        = ($urandom_range(0, 999) == 0);
            train_req  = ($urandom_range(0, 39) == 0);
            rx_error   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) rx_locked = ~rx_locked;
            data_valid = $urandom_range(0, 1);
            data_in    = 8'($urandom);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
